// File: rtl/edge_waveform_generator.sv
// Edge waveform generator: a small command FIFO feeds a two-state sequencer
// that drives dout to each command's level for max(len,1) cycles, back to
// back with no gap, and flags registered rising/falling edges of dout.
module edge_waveform_generator #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_level,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic             dout,
  output logic             rising_edge,
  output logic             falling_edge,
  output logic             either_edge,
  output logic             busy
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             lvl_mem [DEPTH];
  logic [CNT_W-1:0] len_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic [CNT_W-1:0] hold_cnt;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             seg_end;
  logic             head_lvl;
  logic [CNT_W-1:0] head_len;

  // Zero-length commands still occupy one cycle; counter holds cycles left minus one.
  function automatic logic [CNT_W-1:0] hold_load(input logic [CNT_W-1:0] len);
    if (len == '0) begin
      return '0;
    end
    return len - CNT_W'(1);
  endfunction

  assign full      = (count == OCC_W'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full & ~abort;
  // A new segment may start when nothing is active or the active one is on its last cycle.
  assign seg_end   = (state == IDLE) || (hold_cnt == '0);
  assign pop       = ~abort & ~empty & seg_end;
  assign head_lvl  = lvl_mem[rd_ptr];
  assign head_len  = len_mem[rd_ptr];

  // Command storage; payload needs no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      lvl_mem[wr_ptr] <= cmd_level;
      len_mem[wr_ptr] <= cmd_len;
    end
  end

  // FIFO pointers and occupancy; abort flushes everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start/continue on a pop, drop to IDLE when the last segment expires.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (pop) begin
      state_nxt = HOLD;
    end else if ((state == HOLD) && (hold_cnt == '0)) begin
      state_nxt = IDLE;
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy        = (state == HOLD);
    either_edge = rising_edge | falling_edge;
  end

  // Hold counter, waveform level and edge flags, all updated together so pulses align with dout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt     <= '0;
      dout         <= 1'b0;
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
    end else if (abort) begin
      hold_cnt     <= '0;
      dout         <= 1'b0;
      rising_edge  <= 1'b0;
      falling_edge <= dout;
    end else if (pop) begin
      hold_cnt     <= hold_load(head_len);
      dout         <= head_lvl;
      rising_edge  <= head_lvl & ~dout;
      falling_edge <= ~head_lvl & dout;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - CNT_W'(1);
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_waveform_generator.sv
// Testbench for edge_waveform_generator: queue-based reference model compared
// every cycle, directed scenarios pinned by literal waveforms, then random traffic.
module tb_edge_waveform_generator;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_level = 1'b0;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             abort = 1'b0;
  logic             cmd_ready;
  logic             dout;
  logic             rising_edge;
  logic             falling_edge;
  logic             either_edge;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_waveform_generator #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_level   (cmd_level),
    .cmd_len     (cmd_len),
    .abort       (abort),
    .dout        (dout),
    .rising_edge (rising_edge),
    .falling_edge(falling_edge),
    .either_edge (either_edge),
    .busy        (busy)
  );

  // Reference model: pending commands, cycles left in the current segment, output level.
  typedef struct {
    logic lvl;
    int   len;
  } cmd_t;

  cmd_t q[$];
  int   remain = 0;
  logic mdout = 1'b0;
  logic mrise = 1'b0;
  logic mfall = 1'b0;

  task automatic model_step();
    bit   acc;
    cmd_t c;
    acc = cmd_valid && (q.size() < DEPTH) && !abort;
    mrise = 1'b0;
    mfall = 1'b0;
    if (abort) begin
      q.delete();
      remain = 0;
      mfall  = mdout;
      mdout  = 1'b0;
    end else begin
      if (remain <= 1 && q.size() > 0) begin
        c = q.pop_front();
        mrise  = c.lvl && !mdout;
        mfall  = !c.lvl && mdout;
        mdout  = c.lvl;
        remain = (c.len == 0) ? 1 : c.len;
      end else if (remain > 0) begin
        remain = remain - 1;
      end
      if (acc) begin
        c.lvl = cmd_level;
        c.len = int'(cmd_len);
        q.push_back(c);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        remain = 0;
        mdout  = 1'b0;
        mrise  = 1'b0;
        mfall  = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk1("dout",         dout,         mdout);
      chk1("rising_edge",  rising_edge,  mrise);
      chk1("falling_edge", falling_edge, mfall);
      chk1("either_edge",  either_edge,  mrise | mfall);
      chk1("busy",         busy,         remain > 0);
      chk1("cmd_ready",    cmd_ready,    q.size() < DEPTH);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic l, input int n, input int budget, output int waited);
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_level = l;
    cmd_len   = CNT_W'(n);
    while (!cmd_ready && waited < budget) begin
      cyc();
      waited++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL push_timeout actual=not_ready expected=ready t=%0t", $time);
    end
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [15:0] d, output logic [15:0] r,
                         output logic [15:0] f, output logic [15:0] b);
    d = '0; r = '0; f = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d[i] = dout;
      r[i] = rising_edge;
      f[i] = falling_edge;
      b[i] = busy;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    logic [15:0] d, r, f, b;
    int w;

    repeat (3) @(posedge clk);
    #2;
    chk1("rst_dout",      dout,         1'b0);
    chk1("rst_busy",      busy,         1'b0);
    chk1("rst_cmd_ready", cmd_ready,    1'b1);
    chk1("rst_either",    either_edge,  1'b0);
    rst = 1'b1;
    cyc();

    // Single command {1,3}
    fork
      push(1'b1, 3, 10, w);
      capture(7, d, r, f, b);
    join
    cyc();
    chkv("single_dout", d, 16'(7'b1111100));
    chkv("single_rise", r, 16'(7'b0000100));
    chkv("single_busy", b, 16'(7'b0011100));

    // Back-to-back {1,2},{0,4},{1,1}
    do_reset();
    fork
      begin
        push(1'b1, 2, 10, w);
        push(1'b0, 4, 10, w);
        push(1'b1, 1, 10, w);
      end
      capture(10, d, r, f, b);
    join
    cyc();
    chkv("b2b_dout", d, 16'(10'b1100001100));
    chkv("b2b_rise", r, 16'(10'b0100000100));
    chkv("b2b_fall", f, 16'(10'b0000010000));

    // Same level {1,2},{1,3} then {0,0}
    do_reset();
    fork
      begin
        push(1'b1, 2, 10, w);
        push(1'b1, 3, 10, w);
        push(1'b0, 0, 10, w);
      end
      capture(9, d, r, f, b);
    join
    cyc();
    chkv("same_dout", d, 16'(9'b001111100));
    chkv("same_rise", r, 16'(9'b000000100));
    chkv("same_fall", f, 16'(9'b010000000));
    chkv("same_busy", b, 16'(9'b011111100));

    // Abort during {1,10} with two queued, plus a same-cycle command that must be ignored
    do_reset();
    fork
      begin
        push(1'b1, 10, 10, w);
        push(1'b1, 3, 10, w);
        push(1'b1, 5, 10, w);
        cyc();
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_level = 1'b1;
        cmd_len   = CNT_W'(2);
        cyc();
        abort     = 1'b0;
        cmd_valid = 1'b0;
      end
      capture(10, d, r, f, b);
    join
    cyc();
    chkv("abort_dout", d, 16'(10'b0000011100));
    chkv("abort_fall", f, 16'(10'b0000100000));
    chkv("abort_busy", b, 16'(10'b0000011100));
    chk1("abort_ready", cmd_ready, 1'b1);
    repeat (12) cyc();
    chk1("abort_stays_low", dout, 1'b0);

    // Fill: one segment in progress plus DEPTH buffered blocks further pushes
    do_reset();
    repeat (5) push(1'b1, 200, 10, w);
    chk1("fill_ready_low", cmd_ready, 1'b0);
    chk1("fill_busy",      busy,      1'b1);
    push(1'b0, 1, 300, w);
    chki("fill_wait_cycles", w, 197);

    // Asynchronous reset mid-segment with dout high
    do_reset();
    push(1'b1, 50, 10, w);
    repeat (5) cyc();
    chk1("arst_pre_dout", dout, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk1("arst_dout",  dout,         1'b0);
    chk1("arst_fall",  falling_edge, 1'b0);
    chk1("arst_busy",  busy,         1'b0);
    chk1("arst_ready", cmd_ready,    1'b1);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Random traffic against the model
    repeat (3000) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_level = 1'($urandom_range(0, 1));
      cmd_len   = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      abort     = ($urandom_range(0, 49) == 0);
      cyc();
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    repeat (40) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_waveform_generator.md
EDGE_WAVEFORM_GENERATOR -- requirements
Module: edge_waveform_generator

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set command FIFO depth in entries (power of 2, >=2).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the hold-length field and hold counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  SHALL indicate a command is presented.
REQ-006 cmd_ready  output  1  SHALL indicate the FIFO can accept a command.
REQ-007 cmd_level  input  1  SHALL give the level to drive on dout for the command.
REQ-008 cmd_len  input  CNT_W  SHALL give the hold length in clk cycles.
REQ-009 abort  input  1  SHALL be a synchronous request to discard all commands and return dout low.
REQ-010 dout  output  1  SHALL be the generated registered waveform.
REQ-011 rising_edge  output  1  SHALL pulse for one cycle when dout goes 0->1.
REQ-012 falling_edge  output  1  SHALL pulse for one cycle when dout goes 1->0.
REQ-013 either_edge  output  1  SHALL equal rising_edge OR falling_edge.
REQ-014 busy  output  1  SHALL be high while in HOLD state.

Function
REQ-015 Command SHALL be accepted at a rising edge where cmd_valid && cmd_ready && !abort; cmd_ready SHALL equal !full, registered-count based, and not depend on a same-cycle pop.
REQ-016 FIFO SHALL be first-in first-out with wrap-around read/write pointers and an occupancy count of 0..DEPTH; push when full SHALL not occur (cmd_ready low).
REQ-017 FSM SHALL have two states: IDLE (no segment active) and HOLD (segment active).
REQ-018 In IDLE with FIFO non-empty, at the next edge the FSM SHALL pop the head, set dout=cmd_level, load counter = max(cmd_len,1)-1, and enter HOLD.
REQ-019 In HOLD, the counter SHALL decrement by 1 each edge while non-zero.
REQ-020 In HOLD with counter==0 and FIFO non-empty, the FSM SHALL pop the next command at that edge with no gap cycle, so each back-to-back segment lasts exactly max(cmd_len,1) cycles.
REQ-021 In HOLD with counter==0 and FIFO empty, the FSM SHALL enter IDLE and dout SHALL keep its last level.
REQ-022 cmd_len==0 SHALL be treated as 1 cycle.
REQ-023 Latency: command accepted at edge k into an empty FIFO while IDLE SHALL appear on dout after edge k+1.
REQ-024 Edge pulses SHALL be registered and asserted in the same cycle dout shows its new value; a command with the same level as dout SHALL produce no pulse and only extend the level.
REQ-025 Push and pop at the same edge SHALL both take effect; count unchanged.
REQ-026 abort sampled high at an edge SHALL empty the FIFO, clear the counter, enter IDLE, set dout=0 and ignore any same-cycle cmd_valid; falling_edge SHALL pulse if dout was 1.
REQ-027 Counter arithmetic SHALL be unsigned CNT_W bits with no wrap below zero.

Reset
REQ-028 While rst is low: dout=0, rising_edge=0, falling_edge=0, either_edge=0, busy=0, FIFO empty, counter=0, state IDLE, cmd_ready=1.
REQ-029 Reset assertion mid-segment SHALL abandon the segment immediately (asynchronously) without any edge pulse; first edge after deassertion SHALL behave as IDLE with empty FIFO.

Verification
REQ-030 Single command {1,len=3} after reset -> dout high exactly 3 cycles starting edge k+1, rising_edge one cycle at start, dout stays 1 afterward, busy low after 3 cycles.
REQ-031 Back-to-back {1,2},{0,4},{1,1} -> dout 1,1,0,0,0,0,1 with no gap; pulses rise, fall, rise aligned to transitions.
REQ-032 Fill: push 5 commands with busy held long (len=200) -> cmd_ready low after 4 in FIFO + 1 in HOLD... exactly after DEPTH entries buffered; 5th accepted only once a pop frees a slot.
REQ-033 Same level {1,2},{1,3} and {0,0} -> dout high 5 cycles, one rising_edge only, then low 1 cycle with falling_edge.
REQ-034 abort during {1,10} at cycle 4 with 2 queued -> dout 0 next edge, falling_edge pulse, FIFO empty, busy 0, queued commands never appear.
REQ-035 rst low mid-segment with dout=1 -> dout 0 immediately, no falling_edge pulse, cmd_ready 1.
